// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings,
// sample-point positions within a bit period, and the majority vote.
package uart_pkg;

    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_START  = 3'd1;
    localparam logic [2:0] ENC_DATA   = 3'd2;
    localparam logic [2:0] ENC_PARITY = 3'd3;
    localparam logic [2:0] ENC_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ENC_IDLE,
        ST_START  = ENC_START,
        ST_DATA   = ENC_DATA,
        ST_PARITY = ENC_PARITY,
        ST_STOP   = ENC_STOP
    } rx_state_e;

    // First of the three mid-bit samples; the other two follow on consecutive cycles.
    function automatic int first_sample(input int prescale);
        return prescale / 2 - 1;
    endfunction

    // Cycle in which the registered vote is acted on.
    function automatic int decision_point(input int prescale);
        return prescale / 2 + 2;
    endfunction

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the receive controller and the UART top level / deserializer.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int IW = $clog2(DATA_WIDTH);

    logic          rx_in;
    logic          parity_enable;
    logic          parity_type;
    logic          deser_enable;
    logic [IW-1:0] data_index;
    logic          sampled_bit;
    logic          data_valid;
    logic          parity_error;
    logic          framing_error;
    logic          busy;

    modport master (
        input  rx_in, parity_enable, parity_type,
        output deser_enable, data_index, sampled_bit,
               data_valid, parity_error, framing_error, busy
    );

    modport slave (
        output rx_in, parity_enable, parity_type,
        input  deser_enable, data_index, sampled_bit,
               data_valid, parity_error, framing_error, busy
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// Bit-period timing for the receiver: edge counter, three mid-bit samples
// of rx_in and their majority vote.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_in,
    input  logic active,
    input  logic active_next,
    output logic pre_decision,
    output logic decision,
    output logic bit_end,
    output logic vote,
    output logic sampled_bit
);

    localparam int CW  = $clog2(PRESCALE);
    localparam int S0  = first_sample(PRESCALE);
    localparam int S1  = S0 + 1;
    localparam int S2  = S0 + 2;
    localparam int DEC = decision_point(PRESCALE);

    logic [CW-1:0] edge_cnt;
    logic [2:0]    samples;

    assign pre_decision = active && (edge_cnt == CW'(S2));
    assign decision     = active && (edge_cnt == CW'(DEC));
    assign bit_end      = active && (edge_cnt == CW'(PRESCALE - 1));
    assign vote         = majority(samples[0], samples[1], samples[2]);

    // The IDLE cycle that sees the falling edge is edge 0, so counting resumes at 1.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_cnt <= '0;
        end else if (!active_next) begin
            edge_cnt <= '0;
        end else if (!active) begin
            edge_cnt <= CW'(1);
        end else if (bit_end) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    // sampled_bit is registered alongside the third sample so it is valid in the decision cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samples     <= '0;
            sampled_bit <= 1'b0;
        end else if (active) begin
            if (edge_cnt == CW'(S0)) samples[0] <= rx_in;
            if (edge_cnt == CW'(S1)) samples[1] <= rx_in;
            if (pre_decision) begin
                samples[2]  <= rx_in;
                sampled_bit <= majority(samples[0], samples[1], rx_in);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, data bit counter, parity check and
// registered strobes/status towards the deserializer and UART top level.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 16
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_ctrl_if.master bus
);

    localparam int IW = $clog2(DATA_WIDTH);

    rx_state_e     state;
    rx_state_e     state_next;
    logic [IW-1:0] bit_cnt;
    logic [IW-1:0] data_index;
    logic          last_bit;
    logic          par_en;
    logic          par_type;
    logic          par_acc;
    logic          par_flag;
    logic          deser_enable;
    logic          data_valid;
    logic          parity_error;
    logic          framing_error;
    logic          busy;
    logic          active;
    logic          active_next;
    logic          pre_decision;
    logic          decision;
    logic          bit_end;
    logic          vote;
    logic          sampled_bit;

    assign active      = (state != ST_IDLE);
    assign active_next = (state_next != ST_IDLE);
    assign last_bit    = (bit_cnt == IW'(DATA_WIDTH - 1));

    uart_rx_sampler #(
        .PRESCALE (PRESCALE)
    ) u_sampler (
        .clk          (clk),
        .reset        (reset),
        .rx_in        (bus.rx_in),
        .active       (active),
        .active_next  (active_next),
        .pre_decision (pre_decision),
        .decision     (decision),
        .bit_end      (bit_end),
        .vote         (vote),
        .sampled_bit  (sampled_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: next_state gets its default first, so no branch can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (!bus.rx_in) state_next = ST_START;
            ST_START: begin
                if (decision && vote) state_next = ST_IDLE;
                else if (bit_end)     state_next = ST_DATA;
            end
            ST_DATA:   if (bit_end && last_bit) state_next = par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_next = ST_STOP;
            ST_STOP:   if (decision) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Leaving STOP at mid-bit gives IDLE the second half of the stop bit to catch the next edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt       <= '0;
            data_index    <= '0;
            par_en        <= 1'b0;
            par_type      <= 1'b0;
            par_acc       <= 1'b0;
            par_flag      <= 1'b0;
            deser_enable  <= 1'b0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            deser_enable  <= 1'b0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            busy          <= active_next;
            case (state)
                ST_START: begin
                    if (decision && !vote) begin
                        par_en   <= bus.parity_enable;
                        par_type <= bus.parity_type;
                        par_flag <= 1'b0;
                    end
                    if (bit_end) begin
                        bit_cnt <= '0;
                        par_acc <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (pre_decision) begin
                        deser_enable <= 1'b1;
                        data_index   <= bit_cnt;
                    end
                    if (decision) par_acc <= par_acc ^ vote;
                    if (bit_end && !last_bit) bit_cnt <= bit_cnt + 1'b1;
                end
                ST_PARITY: begin
                    if (decision) par_flag <= (vote != (par_acc ^ par_type));
                end
                ST_STOP: begin
                    if (decision) begin
                        framing_error <= !vote;
                        parity_error  <= vote && par_flag;
                        data_valid    <= vote && !par_flag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.deser_enable  = deser_enable;
    assign bus.data_index    = data_index;
    assign bus.sampled_bit   = sampled_bit;
    assign bus.data_valid    = data_valid;
    assign bus.parity_error  = parity_error;
    assign bus.framing_error = framing_error;
    assign bus.busy          = busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl: frames are driven bit by bit and the
// strobes/pulses are logged with their cycle numbers, then compared to hand-computed values.
module tb_uart_rx_ctrl;

    localparam int PRESCALE = 16;
    localparam int DW       = 8;

    logic clk = 1'b0;
    logic reset;

    uart_rx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx_ctrl #(
        .DATA_WIDTH (DW),
        .PRESCALE   (PRESCALE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int t_start;

    int ds_idx[$];
    int ds_bit[$];
    int ds_cyc[$];
    int dv_cyc[$];
    int pe_cyc[$];
    int fe_cyc[$];
    int bf_cyc[$];
    int ds_base, dv_base, pe_base, fe_base, bf_base;
    logic prev_busy = 1'b0;

    // Outputs are read at the falling edge: the value held during cycle 'cyc'.
    always @(negedge clk) begin
        if (bus.deser_enable === 1'b1) begin
            ds_idx.push_back(int'(bus.data_index));
            ds_bit.push_back(int'(bus.sampled_bit));
            ds_cyc.push_back(cyc);
        end
        if (bus.data_valid === 1'b1)    dv_cyc.push_back(cyc);
        if (bus.parity_error === 1'b1)  pe_cyc.push_back(cyc);
        if (bus.framing_error === 1'b1) fe_cyc.push_back(cyc);
        if (prev_busy === 1'b1 && bus.busy === 1'b0) bf_cyc.push_back(cyc);
        prev_busy = bus.busy;
    end

    task automatic mark();
        ds_base = ds_idx.size();
        dv_base = dv_cyc.size();
        pe_base = pe_cyc.size();
        fe_base = fe_cyc.size();
        bf_base = bf_cyc.size();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.rx_in = 1'b1;
        end
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.rx_in = 1'b0;
        end
    endtask

    // glitch_at inverts one cycle (offset from T); stop_after ends the drive early (-1 = full frame).
    task automatic send_frame(input logic [7:0] data, input logic with_par, input logic par_bit,
                              input logic stop_bit, input int glitch_at, input int stop_after);
        logic [10:0] bits;
        int          nbits;
        logic        v;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = data;
        if (with_par) begin
            bits[9]  = par_bit;
            bits[10] = stop_bit;
            nbits    = 11;
        end else begin
            bits[9] = stop_bit;
            nbits   = 10;
        end
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < PRESCALE; c++) begin
                v = bits[b];
                if (b * PRESCALE + c == glitch_at) v = ~v;
                @(posedge clk); #1;
                bus.rx_in = v;
                if (b == 0 && c == 0) t_start = cyc;
                if (b * PRESCALE + c == stop_after) return;
            end
        end
    endtask

    task automatic test_reset();
        reset             = 1'b0;
        bus.rx_in         = 1'b1;
        bus.parity_enable = 1'b0;
        bus.parity_type   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.deser_enable, bus.data_index, bus.sampled_bit, bus.data_valid,
             bus.parity_error, bus.framing_error, bus.busy} !== 9'b0)
            $display("FAIL reset_outputs: got %b expected 000000000",
                     {bus.deser_enable, bus.data_index, bus.sampled_bit, bus.data_valid,
                      bus.parity_error, bus.framing_error, bus.busy});
        else n_pass++;

        // Line low at release counts as a falling edge; a short low is then rejected.
        bus.rx_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL release_low_busy: got %b expected 1", bus.busy);
        else n_pass++;
        bus.rx_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL release_low_rejected: got %b expected 0", bus.busy);
        else n_pass++;
        idle(4);
    endtask

    task automatic test_no_parity();
        logic [7:0] data;
        data = 8'hA5;
        mark();
        send_frame(data, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(6);
        n_checks++;
        if (ds_idx.size() - ds_base !== 8)
            $display("FAIL a5_strobe_count: got %0d expected 8", ds_idx.size() - ds_base);
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (ds_base + k >= ds_idx.size())
                $display("FAIL a5_strobe%0d: strobe missing", k);
            else if (ds_idx[ds_base+k] != k || ds_bit[ds_base+k] != int'(data[k]) ||
                     ds_cyc[ds_base+k] != t_start + (k + 1) * 16 + 10)
                $display("FAIL a5_strobe%0d: got idx %0d bit %0d at T+%0d expected idx %0d bit %0d at T+%0d",
                         k, ds_idx[ds_base+k], ds_bit[ds_base+k], ds_cyc[ds_base+k] - t_start,
                         k, data[k], (k + 1) * 16 + 10);
            else n_pass++;
        end
        n_checks++;
        if (dv_cyc.size() - dv_base != 1 || dv_cyc[dv_base] != t_start + 155)
            $display("FAIL a5_data_valid: got %0d pulses, first at T+%0d expected 1 at T+155",
                     dv_cyc.size() - dv_base, dv_cyc[dv_base] - t_start);
        else n_pass++;
        n_checks++;
        if (pe_cyc.size() - pe_base != 0 || fe_cyc.size() - fe_base != 0)
            $display("FAIL a5_no_errors: got pe %0d fe %0d expected 0 0",
                     pe_cyc.size() - pe_base, fe_cyc.size() - fe_base);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL a5_idle_after: got busy %b expected 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_parity();
        logic ptype  [3] = '{1'b0, 1'b0, 1'b1};
        logic pbit   [3] = '{1'b0, 1'b1, 1'b1};
        int   exp_dv [3] = '{1, 0, 1};
        int   exp_pe [3] = '{0, 1, 0};
        for (int i = 0; i < 3; i++) begin
            bus.parity_enable = 1'b1;
            bus.parity_type   = ptype[i];
            mark();
            send_frame(8'h3C, 1'b1, pbit[i], 1'b1, -1, -1);
            idle(6);
            n_checks++;
            if (ds_idx.size() - ds_base != 8)
                $display("FAIL parity%0d_strobes: got %0d expected 8", i, ds_idx.size() - ds_base);
            else n_pass++;
            n_checks++;
            if (dv_cyc.size() - dv_base != exp_dv[i] ||
                (exp_dv[i] == 1 && dv_cyc[dv_base] != t_start + 171))
                $display("FAIL parity%0d_data_valid: got %0d pulses at T+%0d expected %0d at T+171",
                         i, dv_cyc.size() - dv_base, dv_cyc[dv_base] - t_start, exp_dv[i]);
            else n_pass++;
            n_checks++;
            if (pe_cyc.size() - pe_base != exp_pe[i] ||
                (exp_pe[i] == 1 && pe_cyc[pe_base] != t_start + 171))
                $display("FAIL parity%0d_parity_error: got %0d pulses at T+%0d expected %0d at T+171",
                         i, pe_cyc.size() - pe_base, pe_cyc[pe_base] - t_start, exp_pe[i]);
            else n_pass++;
            n_checks++;
            if (fe_cyc.size() - fe_base != 0)
                $display("FAIL parity%0d_framing: got %0d expected 0", i, fe_cyc.size() - fe_base);
            else n_pass++;
        end
        bus.parity_enable = 1'b0;
        bus.parity_type   = 1'b0;
    endtask

    task automatic test_framing_break();
        mark();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, -1, -1);
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL break_restart_busy: got %b expected 1", bus.busy);
        else n_pass++;
        hold_low(30);
        n_checks++;
        if (fe_cyc.size() - fe_base != 1 || fe_cyc[fe_base] != t_start + 155)
            $display("FAIL break_framing_error: got %0d pulses at T+%0d expected 1 at T+155",
                     fe_cyc.size() - fe_base, fe_cyc[fe_base] - t_start);
        else n_pass++;
        n_checks++;
        if (dv_cyc.size() - dv_base != 0 || pe_cyc.size() - pe_base != 0)
            $display("FAIL break_other_pulses: got dv %0d pe %0d expected 0 0",
                     dv_cyc.size() - dv_base, pe_cyc.size() - pe_base);
        else n_pass++;
        n_checks++;
        if (ds_idx.size() - ds_base != 9 || ds_cyc[ds_base+8] != t_start + 181 ||
            ds_idx[ds_base+8] != 0 || ds_bit[ds_base+8] != 0)
            $display("FAIL break_new_frame: got %0d strobes, 9th idx %0d bit %0d at T+%0d expected 9, idx 0 bit 0 at T+181",
                     ds_idx.size() - ds_base, ds_idx[ds_base+8], ds_bit[ds_base+8], ds_cyc[ds_base+8] - t_start);
        else n_pass++;
        reset     = 1'b0;
        bus.rx_in = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(4);
    endtask

    task automatic test_glitch();
        int t0;
        mark();
        @(posedge clk); #1;
        bus.rx_in = 1'b0;
        t0 = cyc;
        hold_low(2);
        idle(20);
        n_checks++;
        if (ds_idx.size() - ds_base != 0)
            $display("FAIL glitch_no_strobe: got %0d expected 0", ds_idx.size() - ds_base);
        else n_pass++;
        n_checks++;
        if (bf_cyc.size() - bf_base != 1 || bf_cyc[bf_base] != t0 + 11)
            $display("FAIL glitch_busy_fall: got %0d falls, first at T+%0d expected 1 at T+11",
                     bf_cyc.size() - bf_base, bf_cyc[bf_base] - t0);
        else n_pass++;
        n_checks++;
        if (dv_cyc.size() - dv_base + pe_cyc.size() - pe_base + fe_cyc.size() - fe_base != 0)
            $display("FAIL glitch_no_pulse: got %0d end-of-frame pulses expected 0",
                     dv_cyc.size() - dv_base + pe_cyc.size() - pe_base + fe_cyc.size() - fe_base);
        else n_pass++;
    endtask

    task automatic test_majority();
        logic [7:0] got;
        got = '0;
        mark();
        // Offset 56 = centre sample (edge 8) of data bit 2, which sits in bit slot 3.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 56, -1);
        idle(6);
        for (int k = 0; k < 8; k++)
            if (ds_base + k < ds_idx.size()) got[ds_idx[ds_base+k] & 7] = ds_bit[ds_base+k][0];
        n_checks++;
        if (ds_idx.size() - ds_base != 8 || ds_bit[ds_base+2] != 1)
            $display("FAIL majority_bit2: got %0d strobes, bit2 %0d expected 8, 1",
                     ds_idx.size() - ds_base, ds_bit[ds_base+2]);
        else n_pass++;
        n_checks++;
        if (got !== 8'hA5) $display("FAIL majority_byte: got %h expected a5", got);
        else n_pass++;
        n_checks++;
        if (dv_cyc.size() - dv_base != 1 || dv_cyc[dv_base] != t_start + 155)
            $display("FAIL majority_data_valid: got %0d pulses at T+%0d expected 1 at T+155",
                     dv_cyc.size() - dv_base, dv_cyc[dv_base] - t_start);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        got = '0;
        mark();
        send_frame(8'h10, 1'b0, 1'b0, 1'b1, -1, 90);
        n_checks++;
        if ({bus.deser_enable, bus.data_index, bus.sampled_bit} !== 5'b1_100_1)
            $display("FAIL pre_reset_strobe: got %b expected 11001",
                     {bus.deser_enable, bus.data_index, bus.sampled_bit});
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.deser_enable, bus.data_index, bus.sampled_bit, bus.data_valid,
             bus.parity_error, bus.framing_error, bus.busy} !== 9'b0)
            $display("FAIL reset_mid_outputs: got %b expected 000000000",
                     {bus.deser_enable, bus.data_index, bus.sampled_bit, bus.data_valid,
                      bus.parity_error, bus.framing_error, bus.busy});
        else n_pass++;
        bus.rx_in = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(5);
        mark();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(6);
        for (int k = 0; k < 8; k++)
            if (ds_base + k < ds_idx.size()) got[ds_idx[ds_base+k] & 7] = ds_bit[ds_base+k][0];
        n_checks++;
        if (ds_idx.size() - ds_base != 8 || got !== 8'hFF)
            $display("FAIL after_reset_byte: got %0d strobes, byte %h expected 8, ff",
                     ds_idx.size() - ds_base, got);
        else n_pass++;
        n_checks++;
        if (dv_cyc.size() - dv_base != 1 || dv_cyc[dv_base] != t_start + 155)
            $display("FAIL after_reset_data_valid: got %0d pulses at T+%0d expected 1 at T+155",
                     dv_cyc.size() - dv_base, dv_cyc[dv_base] - t_start);
        else n_pass++;
        n_checks++;
        if (pe_cyc.size() - pe_base != 0 || fe_cyc.size() - fe_base != 0)
            $display("FAIL after_reset_errors: got pe %0d fe %0d expected 0 0",
                     pe_cyc.size() - pe_base, fe_cyc.size() - fe_base);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int         t1, t2;
        logic [7:0] b1, b2;
        b1 = '0;
        b2 = '0;
        mark();
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, -1, -1);
        t1 = t_start;
        send_frame(8'h80, 1'b0, 1'b0, 1'b1, -1, -1);
        t2 = t_start;
        idle(6);
        for (int k = 0; k < 8; k++) begin
            if (ds_base + k < ds_idx.size())     b1[ds_idx[ds_base+k] & 7]   = ds_bit[ds_base+k][0];
            if (ds_base + 8 + k < ds_idx.size()) b2[ds_idx[ds_base+8+k] & 7] = ds_bit[ds_base+8+k][0];
        end
        n_checks++;
        if (ds_idx.size() - ds_base != 16)
            $display("FAIL b2b_strobe_count: got %0d expected 16", ds_idx.size() - ds_base);
        else n_pass++;
        n_checks++;
        if (b1 !== 8'h01 || b2 !== 8'h80)
            $display("FAIL b2b_bytes: got %h %h expected 01 80", b1, b2);
        else n_pass++;
        n_checks++;
        if (dv_cyc.size() - dv_base != 2 || dv_cyc[dv_base] != t1 + 155 || dv_cyc[dv_base+1] != t2 + 155)
            $display("FAIL b2b_data_valid: got %0d pulses at T1+%0d, T2+%0d expected 2 at T1+155, T2+155",
                     dv_cyc.size() - dv_base, dv_cyc[dv_base] - t1, dv_cyc[dv_base+1] - t2);
        else n_pass++;
        n_checks++;
        if (pe_cyc.size() - pe_base != 0 || fe_cyc.size() - fe_base != 0)
            $display("FAIL b2b_errors: got pe %0d fe %0d expected 0 0",
                     pe_cyc.size() - pe_base, fe_cyc.size() - fe_base);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity();
        test_framing_break();
        test_glitch();
        test_majority();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sequences the receive-path deserializer. It runs at PRESCALE × baud and detects and validates the start bit. It majority-samples each bit at mid-period and drives the deserializer's enable, bit index and sampled-bit inputs. It checks the optional parity bit and the stop bit, then reports frame completion or errors to the UART top level.

## Interface
- DATA_WIDTH, 8, data bits per frame (≥2); sets data_index width to $clog2(DATA_WIDTH)
- PRESCALE, 16, clk cycles per bit (even, ≥8)
- clk  input  1  oversampling clock, PRESCALE × baud
- reset  input  1  asynchronous, active-low reset
- rx_in  input  1  serial line, already synchronised to clk, idle high
- parity_enable  input  1  1 = frame carries a parity bit after the data bits
- parity_type  input  1  0 = even, 1 = odd
- deser_enable  output  1  one-cycle strobe: deserializer stores sampled_bit at data_index
- data_index  output  $clog2(DATA_WIDTH)  current data bit, LSB first
- sampled_bit  output  1  majority-voted bit value
- data_valid  output  1  one-cycle pulse: frame received without error
- parity_error  output  1  one-cycle pulse: parity mismatch
- framing_error  output  1  one-cycle pulse: stop bit sampled 0
- busy  output  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- edge_cnt counts 0..PRESCALE-1 within a bit and wraps to 0 at each bit boundary.
- bit_cnt counts data bits.
- Sampling:
  - rx_in is registered at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - Decision cycle is edge_cnt = PRESCALE/2+2. Vote = majority of the three samples, driven on sampled_bit.
- IDLE: when rx_in = 0, go to START. The detecting cycle counts as edge_cnt 0, so START begins with edge_cnt = 1.
- START:
  - At the decision cycle, a vote of 1 is a glitch: return to IDLE next cycle with no outputs.
  - Otherwise latch parity_enable and parity_type (ignored for the rest of the frame).
  - At edge_cnt = PRESCALE-1, go to DATA with bit_cnt = 0 and the parity accumulator cleared.
- DATA:
  - At the decision cycle, pulse deser_enable with data_index = bit_cnt, and XOR the vote into the accumulator.
  - At edge_cnt = PRESCALE-1: if bit_cnt = DATA_WIDTH-1, go to PARITY (latched enable = 1) or STOP; otherwise increment bit_cnt.
- PARITY:
  - At the decision cycle, flag a mismatch if vote ≠ (accumulator XOR latched type). The flag is held internally.
  - Go to STOP at bit end.
- STOP:
  - At the decision cycle, go to IDLE next cycle.
  - In that cycle, assert exactly one of: framing_error (vote = 0); else parity_error (flag set); else data_valid.
- Leaving STOP at mid-bit lets a following start bit be detected with no lost edge.
- Line held low (break): reported as framing_error, then treated as a new start bit.
- Reset (asserted at any time, including mid-frame):
  - state IDLE, all counters 0, all outputs 0 (data_index 0).
  - The partial frame is dropped.
  - If rx_in is low at reset release, it is treated as a new falling edge.

## Timing
- T = the cycle in which IDLE first sees rx_in = 0.
- Data bit k strobe: deser_enable in cycle T + (k+1)·PRESCALE + PRESCALE/2 + 2.
- End-of-frame pulse: cycle T + (1 + DATA_WIDTH + P)·PRESCALE + PRESCALE/2 + 3, where P = latched parity_enable.
  - Defaults, no parity: T+155. With parity: T+171.
- Rejected glitch: busy falls in cycle T + PRESCALE/2 + 3.
- All outputs registered; no combinational path from rx_in to any output.

## Structure
- Shared package uart_pkg holds:
  - state encodings (localparams)
  - sample-point constants derived from PRESCALE
- Natural sub-module: uart_rx_sampler, containing the edge counter compare, the three sample registers and the majority vote.
- uart_rx_ctrl holds the FSM, bit_cnt, parity accumulator and output registers.

## Test plan
- Frame 0xA5, no parity, 16 clk/bit, one frame:
  - deser_enable pulses 8 times with index 0..7 and bits 1,0,1,0,0,1,0,1.
  - data_valid at T+155; no errors.
- Frame 0x3C, even parity, correct parity bit 0 → data_valid at T+171. Same frame with parity bit 1 → parity_error only.
- Frame 0x3C, odd parity, parity bit 1 → data_valid.
- Stop bit forced 0 → framing_error only, in the end-of-frame cycle. Line then held low → a new frame starts.
- rx_in low for 3 clk then high → no deser_enable; busy falls at T+11.
- Single-cycle glitch at the centre sample of data bit 2 → correct bit via majority vote.
- Reset asserted at bit 4 → outputs 0 immediately. The next full frame 0xFF is received correctly.
- Two back-to-back frames 0x01, 0x80 with one stop bit → both data_valid; the second start edge is detected.
